// File: rtl/om_port_arbiter.sv
// Three-requester arbiter onto a single output-memory port, with owner tags steering read returns.
// Define OM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build is fixed priority 0 > 1 > 2.
module om_port_arbiter #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic              iWr_req0,
   input  logic [ADDR_W-1:0] iAddr0,
   input  logic [DATA_W-1:0] iData0,
   input  logic              iRd_req1,
   input  logic [ADDR_W-1:0] iAddr1,
   input  logic              iRd_req2,
   input  logic [ADDR_W-1:0] iAddr2,
   output logic [2:0]        oGnt,
   output logic              oOM_rd,
   output logic              oOM_wr,
   output logic [ADDR_W-1:0] oOM_addr,
   output logic [DATA_W-1:0] oOM_wdata,
   input  logic [DATA_W-1:0] iOM_rdata,
   output logic [DATA_W-1:0] oRd_data,
   output logic              oValid1,
   output logic              oValid2,
   output logic              oIdle
);

   localparam int unsigned N_REQ = 3;
   localparam int unsigned TAG_W = 2;
   localparam int unsigned LAST  = RD_LAT - 1;
   localparam logic [TAG_W-1:0] TAG_NONE = 2'b00;

   logic [N_REQ-1:0]  req_c;
   logic [N_REQ-1:0]  gnt_c;
   logic              om_rd_q, om_rd_d;
   logic              om_wr_q, om_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [TAG_W-1:0]  issue_tag_q, issue_tag_d;
   logic [TAG_W-1:0]  tag_q [RD_LAT];
   logic [TAG_W-1:0]  tag_d [RD_LAT];
   logic              tags_busy_c;

   assign req_c = {iRd_req2, iRd_req1, iWr_req0};

`ifdef OM_ARB_ROUND_ROBIN_EN
   localparam logic [1:0] PTR_0 = 2'd0;
   localparam logic [1:0] PTR_1 = 2'd1;
   localparam logic [1:0] PTR_2 = 2'd2;

   logic [1:0] ptr_q, ptr_d;

   // Search order starts at the pointer; pointer moves past the winner only on a grant
   always_comb begin
      gnt_c = '0;
      ptr_d = ptr_q;
      case (ptr_q)
         PTR_1: begin
            if      (req_c[1]) gnt_c = 3'b010;
            else if (req_c[2]) gnt_c = 3'b100;
            else if (req_c[0]) gnt_c = 3'b001;
         end
         PTR_2: begin
            if      (req_c[2]) gnt_c = 3'b100;
            else if (req_c[0]) gnt_c = 3'b001;
            else if (req_c[1]) gnt_c = 3'b010;
         end
         default: begin
            if      (req_c[0]) gnt_c = 3'b001;
            else if (req_c[1]) gnt_c = 3'b010;
            else if (req_c[2]) gnt_c = 3'b100;
         end
      endcase
      if (iReset) gnt_c = '0;
      if      (gnt_c[0]) ptr_d = PTR_1;
      else if (gnt_c[1]) ptr_d = PTR_2;
      else if (gnt_c[2]) ptr_d = PTR_0;
   end

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) ptr_q <= PTR_0;
      else        ptr_q <= ptr_d;
   end
`else
   always_comb begin
      gnt_c = '0;
      if      (req_c[0]) gnt_c = 3'b001;
      else if (req_c[1]) gnt_c = 3'b010;
      else if (req_c[2]) gnt_c = 3'b100;
      if (iReset) gnt_c = '0;
   end
`endif

   // Granted transfer is registered onto the OM port; address and write data hold when idle
   always_comb begin
      om_wr_d     = gnt_c[0];
      om_rd_d     = gnt_c[1] | gnt_c[2];
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      issue_tag_d = gnt_c[2:1];
      if (gnt_c[0]) begin
         addr_d  = iAddr0;
         wdata_d = iData0;
      end else if (gnt_c[1]) begin
         addr_d = iAddr1;
      end else if (gnt_c[2]) begin
         addr_d = iAddr2;
      end
   end

   // Owner tag follows the read strobe through RD_LAT stages to line up with iOM_rdata
   always_comb begin
      tag_d[0]    = issue_tag_q;
      tags_busy_c = 1'b0;
      for (int unsigned i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
      for (int unsigned i = 0; i < RD_LAT; i++) tags_busy_c = tags_busy_c | (tag_q[i] != TAG_NONE);
   end

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         om_rd_q     <= 1'b0;
         om_wr_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         issue_tag_q <= TAG_NONE;
         for (int unsigned i = 0; i < RD_LAT; i++) tag_q[i] <= TAG_NONE;
      end else begin
         om_rd_q     <= om_rd_d;
         om_wr_q     <= om_wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         issue_tag_q <= issue_tag_d;
         tag_q       <= tag_d;
      end
   end

   assign oGnt      = gnt_c;
   assign oOM_rd    = om_rd_q;
   assign oOM_wr    = om_wr_q;
   assign oOM_addr  = addr_q;
   assign oOM_wdata = wdata_q;
   assign oValid1   = tag_q[LAST][0];
   assign oValid2   = tag_q[LAST][1];
   assign oRd_data  = (oValid1 | oValid2) ? iOM_rdata : '0;
   assign oIdle     = ~(|req_c) & ~om_rd_q & ~om_wr_q & ~tags_busy_c;

endmodule

// File: tb/tb_om_port_arbiter.sv
// Bench for om_port_arbiter: directed scenarios plus randomized traffic against a cycle-indexed reference model.
module tb_om_port_arbiter;

   localparam int RD_LAT = 2;

   logic        clk = 1'b0;
   logic        iReset = 1'b1;
   logic        iWr_req0 = 1'b0, iRd_req1 = 1'b0, iRd_req2 = 1'b0;
   logic [12:0] iAddr0 = '0, iAddr1 = '0, iAddr2 = '0;
   logic [31:0] iData0 = '0, iOM_rdata = '0;
   logic [2:0]  oGnt;
   logic        oOM_rd, oOM_wr, oValid1, oValid2, oIdle;
   logic [12:0] oOM_addr;
   logic [31:0] oOM_wdata, oRd_data;

   om_port_arbiter #(.ADDR_W(13), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
      .iClk(clk), .iReset(iReset),
      .iWr_req0(iWr_req0), .iAddr0(iAddr0), .iData0(iData0),
      .iRd_req1(iRd_req1), .iAddr1(iAddr1),
      .iRd_req2(iRd_req2), .iAddr2(iAddr2),
      .oGnt(oGnt), .oOM_rd(oOM_rd), .oOM_wr(oOM_wr),
      .oOM_addr(oOM_addr), .oOM_wdata(oOM_wdata), .iOM_rdata(iOM_rdata),
      .oRd_data(oRd_data), .oValid1(oValid1), .oValid2(oValid2), .oIdle(oIdle)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // OM memory as seen on the DUT port, and the model's own copy updated in grant order
   logic [31:0] ram     [8192];
   logic [31:0] ref_mem [8192];
   logic [31:0] om_due  [int];

   int          m_ptr;
   logic        m_wr, m_rd;
   logic [12:0] m_addr;
   logic [31:0] m_wdata;
   int          m_owner [int];
   logic [31:0] m_rdata [int];
   int          m_pend  [$];

   logic [2:0]  e_gnt;
   logic        e_v1, e_v2, e_idle;
   logic [31:0] e_data;

   function automatic logic [31:0] init_val(input logic [12:0] a);
      return 32'hC0DE_0000 | {19'd0, a};
   endfunction

   function automatic logic [2:0] pick(input logic [2:0] req, input int ptr);
      logic [2:0] g;
      g = '0;
      for (int k = 0; k < 3; k++) begin
         int n;
         n = (ptr + k) % 3;
         if (g == 3'b000 && req[n]) g[n] = 1'b1;
      end
      return g;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_wr = 1'b0; m_rd = 1'b0; m_addr = '0; m_wdata = '0;
      m_owner.delete(); m_rdata.delete(); m_pend.delete();
   endtask

   // Apply this cycle's inputs, present OM read data, and compute the model's expectations
   task automatic drive(input logic r0, input logic [12:0] a0, input logic [31:0] d0,
                        input logic r1, input logic [12:0] a1, input logic r2, input logic [12:0] a2);
      logic busy;
      iWr_req0 = r0; iAddr0 = a0; iData0 = d0;
      iRd_req1 = r1; iAddr1 = a1; iRd_req2 = r2; iAddr2 = a2;
      iOM_rdata = om_due.exists(cyc) ? om_due[cyc] : $urandom;
      e_gnt = iReset ? 3'b000 : pick({r2, r1, r0}, m_ptr);
      e_v1  = m_owner.exists(cyc) && (m_owner[cyc] == 1);
      e_v2  = m_owner.exists(cyc) && (m_owner[cyc] == 2);
      e_data = (e_v1 || e_v2) ? m_rdata[cyc] : 32'h0;
      busy = m_wr || m_rd;
      foreach (m_pend[i]) if (m_pend[i] >= cyc) busy = 1'b1;
      e_idle = !(r0 || r1 || r2) && !busy;
      #1;
   endtask

   task automatic idle_in();
      drive(1'b0, 13'h0, 32'h0, 1'b0, 13'h0, 1'b0, 13'h0);
   endtask

   // Close the cycle: OM port behaviour, model state update, advance to next cycle
   task automatic finish_cycle();
      int n;
      if (oOM_wr) ram[oOM_addr] = oOM_wdata;
      if (oOM_rd) om_due[cyc + RD_LAT] = ram[oOM_addr];
      if (m_wr) ref_mem[m_addr] = m_wdata;
      m_wr = 1'b0;
      m_rd = 1'b0;
      if (e_gnt != 3'b000) begin
         n = e_gnt[0] ? 0 : (e_gnt[1] ? 1 : 2);
         if (n == 0) begin
            m_wr = 1'b1; m_addr = iAddr0; m_wdata = iData0;
         end else begin
            m_rd = 1'b1;
            m_addr = (n == 1) ? iAddr1 : iAddr2;
            m_owner[cyc + 1 + RD_LAT] = n;
            m_rdata[cyc + 1 + RD_LAT] = ref_mem[m_addr];
            m_pend.push_back(cyc + 1 + RD_LAT);
         end
`ifdef OM_ARB_ROUND_ROBIN_EN
         m_ptr = (n + 1) % 3;
`endif
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      iReset = 1'b1;
      model_reset();
      drive(1'b1, 13'h1, 32'h1, 1'b1, 13'h2, 1'b1, 13'h3);
      checks++; if (oGnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got=%b exp=000", oGnt); end
      checks++; if ({oOM_rd, oOM_wr, oValid1, oValid2} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {oOM_rd, oOM_wr, oValid1, oValid2}); end
      checks++; if (oOM_addr !== 13'h0 || oOM_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", oOM_addr, oOM_wdata); end
      finish_cycle();
      idle_in();
      checks++; if (oIdle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", oIdle); end
      finish_cycle();
      iReset = 1'b0;
   endtask

   task automatic test_single_write();
      drive(1'b1, 13'h0123, 32'hDEADBEEF, 1'b0, 13'h0, 1'b0, 13'h0);
      checks++; if (oGnt !== 3'b001) begin errors++; $display("FAIL wr_gnt got=%b exp=001", oGnt); end
      finish_cycle();
      idle_in();
      checks++; if (oOM_wr !== 1'b1 || oOM_rd !== 1'b0) begin errors++; $display("FAIL wr_strobe got wr=%b rd=%b exp wr=1 rd=0", oOM_wr, oOM_rd); end
      checks++; if (oOM_addr !== 13'h0123 || oOM_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_payload got=%h/%h exp=0123/deadbeef", oOM_addr, oOM_wdata); end
      finish_cycle();
      idle_in();
      checks++; if (oOM_wr !== 1'b0 || oOM_addr !== 13'h0123) begin errors++; $display("FAIL wr_one_shot got wr=%b addr=%h exp wr=0 addr=0123", oOM_wr, oOM_addr); end
      checks++; if (oIdle !== 1'b1) begin errors++; $display("FAIL wr_idle got=%b exp=1", oIdle); end
      finish_cycle();
   endtask

   task automatic test_read_latency();
      drive(1'b0, 13'h0, 32'h0, 1'b1, 13'h0A00, 1'b0, 13'h0);
      checks++; if (oGnt !== 3'b010) begin errors++; $display("FAIL rd_gnt got=%b exp=010", oGnt); end
      finish_cycle();
      for (int k = 1; k <= 4; k++) begin
         idle_in();
         if (k == 1) begin
            checks++; if (oOM_rd !== 1'b1 || oOM_addr !== 13'h0A00) begin errors++; $display("FAIL rd_strobe got rd=%b addr=%h exp rd=1 addr=0a00", oOM_rd, oOM_addr); end
         end
         checks++; if (oValid1 !== (k == 1 + RD_LAT)) begin errors++; $display("FAIL rd_valid1 t+%0d got=%b exp=%b", k, oValid1, (k == 1 + RD_LAT)); end
         checks++; if (oValid2 !== 1'b0) begin errors++; $display("FAIL rd_valid2 t+%0d got=%b exp=0", k, oValid2); end
         if (k == 1 + RD_LAT) begin
            checks++; if (oRd_data !== init_val(13'h0A00)) begin errors++; $display("FAIL rd_data got=%h exp=%h", oRd_data, init_val(13'h0A00)); end
         end
         finish_cycle();
      end
   endtask

   task automatic test_contention();
`ifdef OM_ARB_ROUND_ROBIN_EN
      logic [2:0] exp_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
      logic [2:0] exp_seq [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
      test_reset();
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 13'h0100, 32'h5555_0000, 1'b1, 13'h0101, 1'b1, 13'h0102);
         checks++; if (oGnt !== exp_seq[k]) begin errors++; $display("FAIL contention_gnt[%0d] got=%b exp=%b", k, oGnt, exp_seq[k]); end
         finish_cycle();
      end
      for (int k = 0; k < RD_LAT + 3; k++) begin idle_in(); finish_cycle(); end
   endtask

   task automatic test_interleaved();
      drive(1'b0, 13'h0, 32'h0, 1'b1, 13'h0010, 1'b0, 13'h0);
      checks++; if (oGnt !== 3'b010) begin errors++; $display("FAIL il_gnt1 got=%b exp=010", oGnt); end
      finish_cycle();
      drive(1'b0, 13'h0, 32'h0, 1'b0, 13'h0, 1'b1, 13'h0020);
      checks++; if (oGnt !== 3'b100) begin errors++; $display("FAIL il_gnt2 got=%b exp=100", oGnt); end
      finish_cycle();
      for (int k = 2; k <= RD_LAT + 3; k++) begin
         idle_in();
         checks++; if (oValid1 !== (k == 1 + RD_LAT)) begin errors++; $display("FAIL il_valid1 t+%0d got=%b exp=%b", k, oValid1, (k == 1 + RD_LAT)); end
         checks++; if (oValid2 !== (k == 2 + RD_LAT)) begin errors++; $display("FAIL il_valid2 t+%0d got=%b exp=%b", k, oValid2, (k == 2 + RD_LAT)); end
         if (k == 1 + RD_LAT) begin
            checks++; if (oRd_data !== init_val(13'h0010)) begin errors++; $display("FAIL il_data1 got=%h exp=%h", oRd_data, init_val(13'h0010)); end
         end
         if (k == 2 + RD_LAT) begin
            checks++; if (oRd_data !== init_val(13'h0020)) begin errors++; $display("FAIL il_data2 got=%h exp=%h", oRd_data, init_val(13'h0020)); end
         end
         finish_cycle();
      end
   endtask

   task automatic test_write_then_read();
      drive(1'b1, 13'h0030, 32'h1234_5678, 1'b0, 13'h0, 1'b0, 13'h0);
      finish_cycle();
      drive(1'b0, 13'h0, 32'h0, 1'b0, 13'h0, 1'b1, 13'h0030);
      checks++; if (oGnt !== 3'b100) begin errors++; $display("FAIL wtr_gnt got=%b exp=100", oGnt); end
      finish_cycle();
      for (int k = 1; k <= RD_LAT + 1; k++) begin
         idle_in();
         if (k == RD_LAT + 1) begin
            checks++; if (oValid2 !== 1'b1 || oRd_data !== 32'h1234_5678) begin errors++; $display("FAIL wtr_data got v2=%b data=%h exp v2=1 data=12345678", oValid2, oRd_data); end
         end
         finish_cycle();
      end
   endtask

   task automatic test_reset_midflight();
      drive(1'b0, 13'h0, 32'h0, 1'b0, 13'h0, 1'b1, 13'h0040);
      checks++; if (oGnt !== 3'b100) begin errors++; $display("FAIL mf_gnt got=%b exp=100", oGnt); end
      finish_cycle();
      iReset = 1'b1;
      model_reset();
      idle_in();
      finish_cycle();
      iReset = 1'b0;
      for (int k = 0; k < RD_LAT + 4; k++) begin
         idle_in();
         checks++; if (oValid2 !== 1'b0 || oValid1 !== 1'b0) begin errors++; $display("FAIL mf_valid k=%0d got v1=%b v2=%b exp 0/0", k, oValid1, oValid2); end
         checks++; if (oIdle !== 1'b1) begin errors++; $display("FAIL mf_idle k=%0d got=%b exp=1", k, oIdle); end
         finish_cycle();
      end
   endtask

   task automatic test_random();
      logic        p0, p1, p2;
      logic [12:0] a0, a1, a2;
      logic [31:0] d0;
      p0 = 1'b0; p1 = 1'b0; p2 = 1'b0; a0 = '0; a1 = '0; a2 = '0; d0 = '0;
      for (int i = 0; i < 400; i++) begin
         if (i < 390) begin
            if (!p0 && $urandom_range(0, 1) == 1) begin p0 = 1'b1; a0 = 13'($urandom_range(0, 15)); d0 = $urandom; end
            if (!p1 && $urandom_range(0, 1) == 1) begin p1 = 1'b1; a1 = 13'($urandom_range(0, 15)); end
            if (!p2 && $urandom_range(0, 1) == 1) begin p2 = 1'b1; a2 = 13'($urandom_range(0, 15)); end
            if (p2 && $urandom_range(0, 9) == 0) p2 = 1'b0;
         end else begin
            p0 = 1'b0; p1 = 1'b0; p2 = 1'b0;
         end
         drive(p0, a0, d0, p1, a1, p2, a2);
         checks++; if (oGnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, oGnt, e_gnt); end
         checks++; if (oOM_wr !== m_wr || oOM_rd !== m_rd) begin errors++; $display("FAIL rnd_strobe cyc=%0d got wr=%b rd=%b exp wr=%b rd=%b", cyc, oOM_wr, oOM_rd, m_wr, m_rd); end
         checks++; if (oOM_addr !== m_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, oOM_addr, m_addr); end
         checks++; if (oOM_wdata !== m_wdata) begin errors++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, oOM_wdata, m_wdata); end
         checks++; if (oValid1 !== e_v1 || oValid2 !== e_v2) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b%b exp=%b%b", cyc, oValid1, oValid2, e_v1, e_v2); end
         if (e_v1 || e_v2) begin
            checks++; if (oRd_data !== e_data) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, oRd_data, e_data); end
         end
         checks++; if (oIdle !== e_idle) begin errors++; $display("FAIL rnd_idle cyc=%0d got=%b exp=%b", cyc, oIdle, e_idle); end
         if (e_gnt[0]) p0 = 1'b0;
         if (e_gnt[1]) p1 = 1'b0;
         if (e_gnt[2]) p2 = 1'b0;
         finish_cycle();
      end
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) begin
         ram[i]     = init_val(13'(i));
         ref_mem[i] = init_val(13'(i));
      end
      model_reset();
      @(negedge clk);
      test_reset();
      test_single_write();
      test_read_latency();
      test_contention();
      test_interleaved();
      test_write_then_read();
      test_reset_midflight();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/om_port_arbiter.md
OM_PORT_ARBITER -- requirements
Module: om_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, output-memory (OM) address width.
REQ-002 SHALL have parameter DATA_W, default 32, OM data width.
REQ-003 SHALL have parameter RD_LAT, default 2, OM read latency in cycles (legal values 1..4).
REQ-004 iClk  input  1  sole clock, all state on rising edge.
REQ-005 iReset  input  1  asynchronous, active-high reset.
REQ-006 iWr_req0  input  1  requester 0 (classifier) write request.
REQ-007 iAddr0 / iData0  input  ADDR_W / DATA_W  requester 0 write address and data.
REQ-008 iRd_req1 / iAddr1  input  1 / ADDR_W  requester 1 (max-value search) read request and address.
REQ-009 iRd_req2 / iAddr2  input  1 / ADDR_W  requester 2 (host readout) read request and address.
REQ-010 oGnt  output  3  one-hot grant, bit n for requester n.
REQ-011 oOM_rd / oOM_wr  output  1 / 1  OM read and write strobes.
REQ-012 oOM_addr / oOM_wdata  output  ADDR_W / DATA_W  OM address and write data.
REQ-013 iOM_rdata  input  DATA_W  OM read data, valid RD_LAT cycles after oOM_rd.
REQ-014 oRd_data  output  DATA_W  returned read data, shared by requesters 1 and 2.
REQ-015 oValid1 / oValid2  output  1 / 1  oRd_data belongs to requester 1 / 2 this cycle.
REQ-016 oIdle  output  1  no request pending and read tag pipeline empty.

Function
REQ-017 Handshake SHALL be: requester holds req, addr and data stable until the cycle its oGnt bit is 1; transfer occurs in that cycle; req may drop or re-arm next cycle.
REQ-018 oGnt SHALL be combinational from current requests and the priority state; at most one bit set; zero when no request.
REQ-019 A request deasserted before grant SHALL cause no transfer and no state change.
REQ-020 A granted transfer SHALL register onto oOM_rd/oOM_wr/oOM_addr/oOM_wdata exactly 1 cycle after grant; strobes high for exactly 1 cycle per grant.
REQ-021 With no grant, oOM_rd and oOM_wr SHALL be 0 the following cycle; oOM_addr/oOM_wdata hold last value.
REQ-022 Each read issue SHALL push a 2-bit owner tag (01 = req1, 10 = req2, 00 = none) into a RD_LAT-deep shift register advancing every cycle.
REQ-023 When the tag exits, oRd_data SHALL equal iOM_rdata (combinational pass-through) and the matching oValid SHALL be 1 for one cycle; latency from grant to valid = 1 + RD_LAT cycles.
REQ-024 One transfer per cycle SHALL be sustained; back-to-back grants to the same requester allowed.
REQ-025 OM accesses SHALL issue in grant order; a write and a later read to the same address see the written data (ordering delegated to OM).
REQ-026 oIdle SHALL be 1 iff all request inputs are 0, all tags are 00 and no strobe is pending.

Reset
REQ-027 On iReset high, oOM_rd, oOM_wr, oValid1, oValid2 SHALL be 0; oOM_addr, oOM_wdata, oRd_data (registered part) 0; tag pipeline 00; priority pointer = requester 0; oIdle 1 once requests are 0.
REQ-028 Reset mid-operation SHALL discard in-flight read tags; no oValid pulse after reset release for reads issued before it.
REQ-029 oGnt SHALL be 0 while iReset is high.

Configuration
REQ-030 Macro OM_ARB_ROUND_ROBIN_EN defined: round-robin; after granting n, priority order starts at (n+1) mod 3; pointer updates only on a grant.
REQ-031 Macro OM_ARB_ROUND_ROBIN_EN undefined: fixed priority 0 > 1 > 2; no pointer register.

Verification
REQ-032 Single write: iWr_req0=1, iAddr0=0x0123, iData0=0xDEADBEEF -> oGnt=001 same cycle; next cycle oOM_wr=1, oOM_addr=0x0123, oOM_wdata=0xDEADBEEF.
REQ-033 Read latency, RD_LAT=2: iRd_req1=1, iAddr1=0x0A00 granted cycle T -> oOM_rd at T+1; oValid1=1 at T+3 with oRd_data=iOM_rdata; oValid2 stays 0.
REQ-034 Contention, RR enabled: all three requests held for 6 cycles -> oGnt sequence 001,010,100,001,010,100; fixed-priority build -> 001 for all 6.
REQ-035 Interleaved reads: req1 at 0x0010 and req2 at 0x0020 granted back-to-back -> oValid1 then oValid2 on consecutive cycles, each with its own data.
REQ-036 Reset mid-flight: grant read for req2, assert iReset 1 cycle later -> no oValid2 ever; oIdle=1 after release with no requests.
